// File: rtl/mem_responder.sv
// Memory-side responder for the MemoryControl bus: word-addressed on-chip array,
// one single-word access per CEN high period, with programmable read/write wait states.
module mem_responder #(
  parameter int AW        = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_DOUT,
  input  logic        MEM_CEN,
  input  logic        MEM_WR,
  output logic [31:0] MEM_DIN,
  output logic        MEM_RDY,
  output logic        MEM_BUSY,
  output logic        MEM_ERR
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_REARM   = 3'd4;

  localparam logic [3:0] RD_CNT_INIT = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_CNT_INIT = 4'(WRITE_LAT - 1);

  // The controller samples read data 15 cycles after raising CEN, hence the tighter read bound.
  if (READ_LAT < 1 || READ_LAT > 14) begin : g_bad_read_lat
    $error("mem_responder: READ_LAT=%0d outside 1..14", READ_LAT);
  end
  if (WRITE_LAT < 1 || WRITE_LAT > 15) begin : g_bad_write_lat
    $error("mem_responder: WRITE_LAT=%0d outside 1..15", WRITE_LAT);
  end
  if (AW < 1 || AW > 29) begin : g_bad_aw
    $error("mem_responder: AW=%0d outside 1..29", AW);
  end

  logic [2:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [AW-1:0] idx;
  logic          reject;
  logic          mem_we;
  logic [31:0]   mem [2**AW];

  assign idx    = addr_q[AW+1:2];
  assign reject = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
  // Gating with rst is what makes a reset mid-access drop the pending write.
  assign mem_we = (state == S_WR_WAIT) && (cnt == 4'd0) && !reject && !rst;

  // NOTE: the array has no reset; clearing it would turn block RAM into flops.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= data_q;
    end
  end

  // Request latches only load on accept, so bus activity during the wait is ignored.
  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && MEM_CEN) begin
      addr_q <= MEM_ADDR;
      data_q <= MEM_DOUT;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      MEM_DIN  <= 32'h0;
      MEM_RDY  <= 1'b0;
      MEM_BUSY <= 1'b0;
      MEM_ERR  <= 1'b0;
    end else begin
      MEM_RDY <= 1'b0;
      MEM_ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (MEM_CEN) begin
            MEM_BUSY <= 1'b1;
            if (MEM_WR) begin
              cnt   <= WR_CNT_INIT;
              state <= S_WR_WAIT;
            end else begin
              cnt   <= RD_CNT_INIT;
              state <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (cnt == 4'd0) begin
            MEM_DIN <= reject ? 32'h0 : mem[idx];
            MEM_RDY <= 1'b1;
            MEM_ERR <= reject;
            state   <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WR_WAIT: begin
          if (cnt == 4'd0) begin
            MEM_RDY <= 1'b1;
            MEM_ERR <= reject;
            state   <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (MEM_CEN) begin
            state <= S_REARM;
          end else begin
            state    <= S_IDLE;
            MEM_BUSY <= 1'b0;
          end
        end
        S_REARM: begin
          if (!MEM_CEN) begin
            state    <= S_IDLE;
            MEM_BUSY <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          MEM_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
